// File: rtl/move_receiver.sv
// Authoritative 8x8 board: latches 12-bit move packets, checks ownership, then commits or
// rejects them while tracking turn order and king capture.
module move_receiver (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 new_game,
  input  logic                 pkt_valid,
  input  logic [11:0]          pkt,
  output logic                 pkt_ready,
  output logic [7:0][7:0][3:0] stable_board,
  output logic                 curr_player,
  output logic                 applied,
  output logic                 rejected,
  output logic [3:0]           captured,
  output logic                 won,
  output logic                 winner
);

  typedef enum logic [2:0] {StIdle, StFetch, StCheck, StCommit, StGameOver} state_e;

  localparam logic [3:0] Empty = 4'd15;
  // Concatenations list x=7 first, so back rows read right-to-left here.
  localparam logic [7:0][3:0] Row0 = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd3, 4'd2, 4'd1};
  localparam logic [7:0][3:0] Row7 = {4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd9, 4'd8, 4'd7};
  localparam logic [7:0][7:0][3:0] InitBoard = {Row7, {8{4'd6}}, {32{Empty}}, {8{4'd0}}, Row0};

  function automatic logic owner_of(input logic [3:0] code);
    return code < 4'd6;
  endfunction

  state_e               r_state;
  logic                 r_ready;
  logic [7:0][7:0][3:0] r_board;
  logic                 r_curr;
  logic                 r_applied;
  logic                 r_rejected;
  logic [3:0]           r_captured;
  logic                 r_won;
  logic                 r_winner;
  logic [2:0]           r_ox, r_oy, r_nx, r_ny;
  logic [3:0]           r_src, r_dst;

  logic       w_reject;
  logic [3:0] w_piece;
  logic       w_king_hit;

  // Codes above 11 (including empty) never belong to the mover.
  assign w_reject = (r_src > 4'd11) ||
                    (owner_of(r_src) != r_curr) ||
                    ((r_dst != Empty) && (owner_of(r_dst) == r_curr)) ||
                    ((r_ox == r_nx) && (r_oy == r_ny));

  always_comb begin
    w_piece = r_src;
    if (r_src == 4'd0 && r_ny == 3'd7) w_piece = 4'd5;
    if (r_src == 4'd6 && r_ny == 3'd0) w_piece = 4'd11;
  end

  assign w_king_hit = (r_dst == 4'd4) || (r_dst == 4'd10);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_ready    <= 1'b0;
      r_board    <= InitBoard;
      r_curr     <= 1'b1;
      r_applied  <= 1'b0;
      r_rejected <= 1'b0;
      r_captured <= Empty;
      r_won      <= 1'b0;
      r_winner   <= 1'b0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_nx       <= '0;
      r_ny       <= '0;
      r_src      <= Empty;
      r_dst      <= Empty;
    end else if (new_game) begin
      r_state    <= StIdle;
      r_ready    <= 1'b1;
      r_board    <= InitBoard;
      r_curr     <= 1'b1;
      r_applied  <= 1'b0;
      r_rejected <= 1'b0;
      r_captured <= Empty;
      r_won      <= 1'b0;
      r_winner   <= 1'b0;
    end else begin
      r_applied  <= 1'b0;
      r_rejected <= 1'b0;
      case (r_state)
        StIdle: begin
          if (pkt_valid && r_ready) begin
            {r_ox, r_oy, r_nx, r_ny} <= pkt;
            r_state <= StFetch;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        StFetch: begin
          r_src   <= r_board[r_oy][r_ox];
          r_dst   <= r_board[r_ny][r_nx];
          r_state <= StCheck;
        end
        StCheck: begin
          if (w_reject) begin
            r_rejected <= 1'b1;
          end else begin
            r_board[r_ny][r_nx] <= w_piece;
            r_board[r_oy][r_ox] <= Empty;
            r_captured          <= r_dst;
            r_curr              <= ~r_curr;
            r_applied           <= 1'b1;
            if (w_king_hit) begin
              r_won    <= 1'b1;
              r_winner <= r_curr;
            end
          end
          r_state <= StCommit;
        end
        StCommit: begin
          if (r_won) begin
            r_state <= StGameOver;
            r_ready <= 1'b0;
          end else begin
            r_state <= StIdle;
            r_ready <= 1'b1;
          end
        end
        StGameOver: begin
          r_ready <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_ready    = r_ready;
  assign stable_board = r_board;
  assign curr_player  = r_curr;
  assign applied      = r_applied;
  assign rejected     = r_rejected;
  assign captured     = r_captured;
  assign won          = r_won;
  assign winner       = r_winner;

endmodule

// File: tb/tb_move_receiver.sv
// Self-checking bench for move_receiver: transaction-level board model, per-cycle compare,
// directed scenarios with literal expectations, then randomized packet traffic.
module tb_move_receiver;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset = 1'b1;
  logic                 new_game = 1'b0;
  logic                 pkt_valid = 1'b0;
  logic [11:0]          pkt = '0;
  logic                 pkt_ready;
  logic [7:0][7:0][3:0] stable_board;
  logic                 curr_player;
  logic                 applied;
  logic                 rejected;
  logic [3:0]           captured;
  logic                 won;
  logic                 winner;

  move_receiver dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .new_game    (new_game),
    .pkt_valid   (pkt_valid),
    .pkt         (pkt),
    .pkt_ready   (pkt_ready),
    .stable_board(stable_board),
    .curr_player (curr_player),
    .applied     (applied),
    .rejected    (rejected),
    .captured    (captured),
    .won         (won),
    .winner      (winner)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  localparam logic [3:0] Back1 [8] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [3:0] Back0 [8] = '{4'd7, 4'd8, 4'd9, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7};

  int n_cmp = 0;
  int n_bad = 0;

  // Model: board plus game state, and the age (in edges) of the packet in flight.
  logic [3:0]  m_board [8][8];
  logic        m_curr, m_won, m_winner, m_ready, m_applied, m_rejected;
  logic [3:0]  m_captured;
  logic [11:0] m_pkt;
  int          m_age;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_init();
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (y == 0)      m_board[y][x] = Back1[x];
        else if (y == 1) m_board[y][x] = 4'd0;
        else if (y == 6) m_board[y][x] = 4'd6;
        else if (y == 7) m_board[y][x] = Back0[x];
        else             m_board[y][x] = 4'd15;
      end
    end
    m_curr     = 1'b1;
    m_won      = 1'b0;
    m_winner   = 1'b0;
    m_captured = 4'd15;
    m_applied  = 1'b0;
    m_rejected = 1'b0;
    m_age      = -1;
  endtask

  function automatic logic player_of(input logic [3:0] c);
    return (c <= 4'd5) ? 1'b1 : 1'b0;
  endfunction

  task automatic m_apply();
    int ox, oy, nx, ny;
    logic [3:0] src, dst, piece;
    ox = int'(m_pkt[11:9]);
    oy = int'(m_pkt[8:6]);
    nx = int'(m_pkt[5:3]);
    ny = int'(m_pkt[2:0]);
    src = m_board[oy][ox];
    dst = m_board[ny][nx];
    if (src >= 4'd12 || player_of(src) != m_curr ||
        (dst != 4'd15 && player_of(dst) == m_curr) || (ox == nx && oy == ny)) begin
      m_rejected = 1'b1;
    end else begin
      piece = src;
      if (src == 4'd0 && ny == 7) piece = 4'd5;
      if (src == 4'd6 && ny == 0) piece = 4'd11;
      m_board[ny][nx] = piece;
      m_board[oy][ox] = 4'd15;
      m_captured = dst;
      if (dst == 4'd4 || dst == 4'd10) begin
        m_won    = 1'b1;
        m_winner = m_curr;
      end
      m_curr    = ~m_curr;
      m_applied = 1'b1;
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_init();
      m_ready = 1'b0;
    end else if (new_game) begin
      m_init();
      m_ready = 1'b1;
    end else begin
      m_applied  = 1'b0;
      m_rejected = 1'b0;
      if (m_age >= 0) begin
        m_age++;
        if (m_age == 2) m_apply();
        else if (m_age == 3) m_age = -1;
      end else if (m_ready && pkt_valid) begin
        m_pkt = pkt;
        m_age = 0;
      end
      m_ready = (m_age < 0) && !m_won;
    end
  endtask

  task automatic compare_all();
    logic [7:0][7:0][3:0] e;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) e[y][x] = m_board[y][x];
    chk("pkt_ready", 256'(pkt_ready), 256'(m_ready));
    chk("applied", 256'(applied), 256'(m_applied));
    chk("rejected", 256'(rejected), 256'(m_rejected));
    chk("curr_player", 256'(curr_player), 256'(m_curr));
    chk("captured", 256'(captured), 256'(m_captured));
    chk("won", 256'(won), 256'(m_won));
    if (m_won) chk("winner", 256'(winner), 256'(m_winner));
    chk("board", 256'(stable_board), 256'(e));
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    compare_all();
  endtask

  function automatic logic [11:0] mk(input int ox, input int oy, input int nx, input int ny);
    return {3'(ox), 3'(oy), 3'(nx), 3'(ny)};
  endfunction

  task automatic send(input logic [11:0] p, output logic got_app, output logic got_rej);
    for (int i = 0; i < 20 && pkt_ready !== 1'b1; i++) tick();
    chk("ready_wait", 256'(pkt_ready), 256'(1'b1));
    pkt_valid = 1'b1;
    pkt       = p;
    tick();
    pkt_valid = 1'b0;
    tick();
    tick();
    got_app = applied;
    got_rej = rejected;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, r;
    logic [11:0] seq [8];
    m_init();
    m_ready = 1'b0;
    do_reset();
    chk("init_b03", 256'(stable_board[0][3]), 256'(4'd5));
    chk("init_b74", 256'(stable_board[7][4]), 256'(4'd10));
    chk("init_b60", 256'(stable_board[6][0]), 256'(4'd6));
    chk("init_curr", 256'(curr_player), 256'(1'b1));
    chk("init_ready", 256'(pkt_ready), 256'(1'b1));

    // Plain commit of a player-1 pawn.
    send(mk(4, 1, 4, 3), a, r);
    chk("commit_applied", 256'({a, r}), 256'(2'b10));
    chk("commit_dst", 256'(stable_board[3][4]), 256'(4'd0));
    chk("commit_src", 256'(stable_board[1][4]), 256'(4'd15));
    chk("commit_curr", 256'(curr_player), 256'(1'b0));
    chk("commit_capt", 256'(captured), 256'(4'd15));

    do_reset();
    send(mk(4, 6, 4, 4), a, r);
    chk("own_rej", 256'({a, r}), 256'(2'b01));
    chk("own_curr", 256'(curr_player), 256'(1'b1));
    chk("own_board", 256'(stable_board[6][4]), 256'(4'd6));
    send(mk(3, 3, 3, 4), a, r);
    chk("empty_rej", 256'({a, r}), 256'(2'b01));
    chk("empty_ready", 256'(pkt_ready), 256'(1'b1));
    send(mk(0, 0, 0, 1), a, r);
    chk("self_rej", 256'({a, r}), 256'(2'b01));
    chk("self_ready", 256'(pkt_ready), 256'(1'b1));

    // Queen takes the opposing king directly; geometry is not checked.
    send(mk(3, 0, 4, 7), a, r);
    chk("king_applied", 256'({a, r}), 256'(2'b10));
    chk("king_capt", 256'(captured), 256'(4'd10));
    chk("king_won", 256'({won, winner}), 256'(2'b11));
    pkt_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pkt = 12'($urandom);
      tick();
      chk("gameover_ready", 256'(pkt_ready), 256'(1'b0));
    end
    pkt_valid = 1'b0;
    new_game  = 1'b1;
    tick();
    new_game  = 1'b0;
    chk("ng_ready", 256'(pkt_ready), 256'(1'b1));
    chk("ng_b74", 256'(stable_board[7][4]), 256'(4'd10));
    chk("ng_won", 256'(won), 256'(1'b0));

    // Promotion for both colours.
    seq = '{mk(0, 1, 0, 5), mk(0, 7, 0, 4), mk(0, 5, 0, 6), mk(1, 6, 1, 2),
            mk(0, 6, 0, 7), mk(1, 2, 1, 1), mk(0, 0, 0, 3), mk(1, 1, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      send(seq[i], a, r);
      chk("promo_seq_applied", 256'({a, r}), 256'(2'b10));
      if (i == 4) chk("promo_p1", 256'(stable_board[7][0]), 256'(4'd5));
    end
    chk("promo_p0", 256'(stable_board[0][0]), 256'(4'd11));

    // new_game while the packet sits in CHECK.
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    pkt_valid = 1'b1;
    pkt       = mk(4, 1, 4, 3);
    tick();
    pkt_valid = 1'b0;
    tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("abort_pulse", 256'({applied, rejected}), 256'(2'b00));
    chk("abort_b14", 256'(stable_board[1][4]), 256'(4'd0));
    chk("abort_b34", 256'(stable_board[3][4]), 256'(4'd15));
    tick();
    tick();
    chk("abort_nopulse", 256'({applied, rejected}), 256'(2'b00));

    // pkt_valid held high with a changing packet.
    pkt_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      pkt = ($urandom_range(0, 1) == 0) ? 12'($urandom) :
            mk($urandom_range(0, 7), 1, $urandom_range(0, 7), $urandom_range(2, 5));
      tick();
    end

    // Randomized traffic with occasional restarts and asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if (reset) reset = 1'b0;
      new_game  = ($urandom_range(0, 39) == 0);
      pkt_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        pkt = 12'($urandom);
      end else begin
        pkt = mk($urandom_range(0, 7), ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1) :
                 $urandom_range(6, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        #1;
        chk("async_rst_out", 256'({pkt_ready, applied, rejected, curr_player, won}),
            256'(5'b00010));
        chk("async_rst_capt", 256'(captured), 256'(4'd15));
        chk("async_rst_b04", 256'(stable_board[0][4]), 256'(4'd4));
        chk("async_rst_b14", 256'(stable_board[1][4]), 256'(4'd0));
      end
      tick();
    end
    reset     = 1'b0;
    pkt_valid = 1'b0;
    new_game  = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
